// File: rtl/instr_issue.sv
// Instruction issue stage: streams a loaded program to the ALU, inserting NOP
// bubbles on read-after-write hazards, then drains two slots and pulses done.
module instr_issue #(
    parameter int          DEPTH     = 64,
    parameter logic [15:0] NOP_INSTR = 16'hF000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic [15:0]   instr,
    output logic          issue_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [15:0]   bubble_count
);

    // state | meaning
    // IDLE  | waiting for start, memory writable
    // RUN   | issuing program words or bubbles
    // DRAIN | two NOP slots to flush the ALU pipeline
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    logic [15:0] imem [DEPTH];
    logic [AW:0] pc_q;
    logic [AW:0] len_q;
    logic [AW:0] len_eff;
    logic        h1_v, h2_v;
    logic [3:0]  h1_d, h2_d;
    logic        drain_second;

    logic [15:0] cand;
    logic [3:0]  op;
    logic        rd_a_en, rd_b_en, wr_en;
    logic        hazard;

    assign len_eff = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign cand    = imem[pc_q[AW-1:0]];
    assign op      = cand[15:12];

    always_comb begin
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        wr_en   = 1'b1;
        case (op)
            4'd15: begin rd_a_en = 1'b0; rd_b_en = 1'b0; wr_en = 1'b0; end
            4'd13: begin rd_a_en = 1'b0; rd_b_en = 1'b0; end
            4'd14: begin rd_a_en = 1'b0; wr_en = 1'b0; end
            default: ;
        endcase
        hazard = (rd_a_en && ((h1_v && h1_d == cand[11:8]) || (h2_v && h2_d == cand[11:8])))
              || (rd_b_en && ((h1_v && h1_d == cand[7:4])  || (h2_v && h2_d == cand[7:4])));
    end

    // Program memory has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && load_en && state == IDLE)
            imem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            instr        <= NOP_INSTR;
            issue_valid  <= 1'b0;
            pc_q         <= '0;
            len_q        <= '0;
            done         <= 1'b0;
            bubble_count <= '0;
            h1_v         <= 1'b0;
            h1_d         <= '0;
            h2_v         <= 1'b0;
            h2_d         <= '0;
            drain_second <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    instr       <= NOP_INSTR;
                    issue_valid <= 1'b0;
                    if (start) begin
                        pc_q         <= '0;
                        len_q        <= len_eff;
                        bubble_count <= '0;
                        h1_v         <= 1'b0;
                        h2_v         <= 1'b0;
                        drain_second <= 1'b0;
                        state        <= (len_eff == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    h2_v <= h1_v;
                    h2_d <= h1_d;
                    if (hazard) begin
                        instr       <= NOP_INSTR;
                        issue_valid <= 1'b0;
                        h1_v        <= 1'b0;
                        if (bubble_count != 16'hFFFF)
                            bubble_count <= bubble_count + 16'd1;
                    end else begin
                        instr       <= cand;
                        issue_valid <= 1'b1;
                        h1_v        <= wr_en;
                        h1_d        <= cand[3:0];
                        pc_q        <= pc_q + (AW+1)'(1);
                        if (pc_q == len_q - (AW+1)'(1)) begin
                            state        <= DRAIN;
                            drain_second <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    instr       <= NOP_INSTR;
                    issue_valid <= 1'b0;
                    h2_v        <= h1_v;
                    h2_d        <= h1_d;
                    h1_v        <= 1'b0;
                    if (drain_second) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_second <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign pc   = pc_q[AW-1:0];

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed and random programs checked
// against a register-ready-time scheduling model.
module tb_instr_issue;
    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [15:0] NOP   = 16'hF000;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic [15:0]   instr;
    logic          issue_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [15:0]   bubble_count;

    instr_issue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .prog_len(prog_len),
        .instr(instr), .issue_valid(issue_valid), .pc(pc), .busy(busy),
        .done(done), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] mem_model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] read_mask(input logic [15:0] w);
        logic [15:0] m;
        case (w[15:12])
            4'd15, 4'd13: m = 16'h0;
            4'd14:        m = 16'h1 << w[7:4];
            default:      m = (16'h1 << w[11:8]) | (16'h1 << w[7:4]);
        endcase
        return m;
    endfunction

    function automatic int dest_of(input logic [15:0] w);
        if (w[15:12] == 4'd15 || w[15:12] == 4'd14) return -1;
        return int'(w[3:0]);
    endfunction

    task automatic load(input int a, input logic [15:0] w);
        load_en   = 1'b1;
        load_addr = a[AW-1:0];
        load_data = w;
        @(negedge clk);
        load_en = 1'b0;
        mem_model[a] = w;
    endtask

    // Caller is at a negedge; start is driven immediately so back-to-back
    // calls exercise start coinciding with done.
    task automatic run_prog(input int plen, input bit disturb);
        int len;
        int ready [16];
        int slot [DEPTH];
        int t, T, idx, d;
        logic [15:0] m;
        logic        ev;
        logic [15:0] ei;
        len = (plen > DEPTH) ? DEPTH : plen;
        for (int r = 0; r < 16; r++) ready[r] = 0;
        t = 0;
        // A result written in slot s is readable from slot s+3 onward.
        for (int i = 0; i < len; i++) begin
            int s;
            s = t + 1;
            m = read_mask(mem_model[i]);
            for (int r = 0; r < 16; r++)
                if (m[r] && ready[r] > s) s = ready[r];
            slot[i] = s;
            t = s;
            d = dest_of(mem_model[i]);
            if (d >= 0) ready[d] = s + 3;
        end
        T = t;
        start    = 1'b1;
        prog_len = plen[AW:0];
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("instr_after_start", instr, NOP);
        idx = 0;
        for (int k = 1; k <= T + 2; k++) begin
            if (disturb && (k == 1 || k == 2)) begin
                start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 16'h0000;
                prog_len = 7'd1;
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            @(negedge clk);
            ev = (idx < len) && (slot[idx] == k);
            ei = ev ? mem_model[idx] : NOP;
            if (ev) idx++;
            chk("instr", instr, ei);
            chk("issue_valid", issue_valid, ev);
            chk("pc", pc, idx % DEPTH);
            chk("done", done, k == T + 2);
            chk("busy", busy, k < T + 2);
        end
        start   = 1'b0;
        load_en = 1'b0;
        chk("bubble_count", bubble_count, T - len);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_valid"}, issue_valid, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bubbles"}, bubble_count, 0);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; prog_len = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        load(0, 16'h2123); load(1, 16'h0567); load(2, 16'h1894);
        run_prog(3, 1'b0);
        load(0, 16'h2123); load(1, 16'h2344);
        run_prog(2, 1'b0);
        load(0, 16'h2123); load(1, 16'h0567); load(2, 16'h2344);
        run_prog(3, 1'b0);
        load(0, 16'hD005); load(1, 16'hE050);
        run_prog(2, 1'b0);
        load(0, 16'hE050); load(1, 16'h2123);
        run_prog(2, 1'b0);
        run_prog(0, 1'b0);

        // start/load during busy are dropped; the chained rerun also starts on done
        load(0, 16'h2123); load(1, 16'h0567); load(2, 16'h1894);
        run_prog(3, 1'b1);
        run_prog(3, 1'b0);

        // reset aborts a run with no done pulse
        start = 1'b1; prog_len = 7'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrun_rst");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        for (int i = 0; i < DEPTH; i++)
            load(i, {4'h1, 4'hE, 4'hF, 4'(i % 14)});
        run_prog(DEPTH, 1'b0);
        run_prog(100, 1'b0);

        for (int p = 0; p < 30; p++) begin
            int len;
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
                load(i, {4'($urandom_range(0, 15)), 2'b00, 2'($urandom),
                         2'b00, 2'($urandom), 2'b00, 2'($urandom)});
            run_prog(len, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
